// File: rtl/key_counter_debounce_pkg.sv
// key_counter_debounce_pkg: shared key FSM encodings and count width
package key_counter_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam logic KEY_PRESSED = 1'b0;
    localparam int   D_W         = 4;

endpackage

// File: rtl/key_counter_debounce_key_debounce.sv
// key_debounce: synchronizer plus stable-time qualification FSM for one active-low key
module key_debounce
    import key_counter_debounce_pkg::*;
#(
    parameter int STABLE_CYC = 1_000_000,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic pulse_o,
    output logic level_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYC - 1);

    logic [1:0]       sync_q;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             pressed;

    assign pressed = sync_q[1] == KEY_PRESSED;

    // synchronizer resets to the released value so a held key re-qualifies
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) state_d = IDLE;
                else if (cnt_q == LAST) state_d = PRESSED;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) state_d = PRESSED;
                else if (cnt_q == LAST) state_d = IDLE;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pulse_d = (state_q == PRESS_WAIT) && (state_d == PRESSED);
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule

// File: rtl/key_counter_debounce.sv
// key_counter_debounce: two debounced keys stepping a wrapping hex up/down count
module key_counter_debounce
    import key_counter_debounce_pkg::*;
#(
    parameter int STABLE_CYC = 1_000_000,
    parameter int CNT_W      = 20
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_up_n,
    input  logic           key_dn_n,
    output logic [D_W-1:0] d_out,
    output logic           up_pulse,
    output logic           dn_pulse,
    output logic           up_level,
    output logic           dn_level
);

    logic [D_W-1:0] d_q, d_d;

    key_debounce #(.STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W)) u_up (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_up_n),
        .pulse_o (up_pulse),
        .level_o (up_level)
    );

    key_debounce #(.STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W)) u_dn (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_dn_n),
        .pulse_o (dn_pulse),
        .level_o (dn_level)
    );

    // simultaneous pulses cancel; natural 4-bit overflow gives the hex wrap
    always_comb begin
        d_d = (up_pulse && !dn_pulse) ? d_q + D_W'(1) :
              (dn_pulse && !up_pulse) ? d_q - D_W'(1) : d_q;
    end

    always_ff @(posedge clk) begin
        if (rst) d_q <= '0;
        else d_q <= d_d;
    end

    assign d_out = d_q;

endmodule

// File: tb/tb_key_counter_debounce.sv
// tb_key_counter_debounce: randomized and directed checks against a run-length debounce model
module tb_key_counter_debounce;

    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic [3:0] d_out;
    logic       up_pulse, dn_pulse, up_level, dn_level;

    int checks = 0;
    int errors = 0;

    int md, ru, rd, nu, nd;
    bit mpu, mpd, mlu, mld;
    bit hu0, hu1, hd0, hd1;

    always #5 clk = ~clk;

    key_counter_debounce #(.STABLE_CYC(S), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_up_n (key_up_n),
        .key_dn_n (key_dn_n),
        .d_out    (d_out),
        .up_pulse (up_pulse),
        .dn_pulse (dn_pulse),
        .up_level (up_level),
        .dn_level (dn_level)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // level flips once S+1 consecutive synchronized samples disagree with it
    task automatic key_model(input bit raw_n, inout int run, inout bit lvl, output bit pul);
        bit pr;
        pr  = (raw_n == 1'b0);
        pul = 1'b0;
        run = (pr != lvl) ? run + 1 : 0;
        if (run == S + 1) begin
            lvl = pr;
            run = 0;
            pul = pr;
        end
    endtask

    task automatic step(input bit u, input bit d, input bit r);
        key_up_n = u;
        key_dn_n = d;
        rst      = r;
        @(posedge clk);
        if (r) begin
            md = 0; ru = 0; rd = 0;
            mpu = 0; mpd = 0; mlu = 0; mld = 0;
            hu0 = 1; hu1 = 1; hd0 = 1; hd1 = 1;
        end else begin
            md = (mpu && !mpd) ? (md + 1) % 16 : (mpd && !mpu) ? (md + 15) % 16 : md;
            key_model(hu1, ru, mlu, mpu);
            key_model(hd1, rd, mld, mpd);
            hu1 = hu0; hu0 = u;
            hd1 = hd0; hd0 = d;
        end
        #1;
        check("d_out", int'(d_out), md);
        check("up_pulse", int'(up_pulse), int'(mpu));
        check("dn_pulse", int'(dn_pulse), int'(mpd));
        check("up_level", int'(up_level), int'(mlu));
        check("dn_level", int'(dn_level), int'(mld));
        nu += int'(up_pulse);
        nd += int'(dn_pulse);
    endtask

    task automatic press(input bit u, input bit d);
        repeat (14) step(u, d, 0);
        repeat (14) step(1, 1, 0);
    endtask

    initial begin
        int first, fall, co;
        bit tu, td, bu, bd;
        int hold;
        md = 0; ru = 0; rd = 0; nu = 0; nd = 0;
        mpu = 0; mpd = 0; mlu = 0; mld = 0;
        hu0 = 1; hu1 = 1; hd0 = 1; hd1 = 1;

        repeat (2) step(1, 1, 1);
        repeat (4) step(1, 1, 0);
        check("rst_d_out", int'(d_out), 0);
        check("rst_levels", int'(up_level) + int'(dn_level), 0);

        nu = 0; first = 0;
        for (int i = 1; i <= 30; i++) begin
            step(0, 1, 0);
            if (up_pulse && first == 0) first = i;
        end
        check("p2_pulse_edge", first, S + 3);
        check("p2_pulses", nu, 1);
        check("p2_level_held", int'(up_level), 1);
        fall = 0;
        for (int i = 1; i <= 14; i++) begin
            step(1, 1, 0);
            if (!up_level && fall == 0) fall = i;
        end
        check("p2_level_fall", fall, S + 3);
        check("p2_d_out", int'(d_out), 1);

        nu = 0;
        for (int i = 0; i < 18; i++) step(((i / 3) % 2) == 1, 1, 0);
        repeat (20) step(0, 1, 0);
        repeat (14) step(1, 1, 0);
        check("p3_pulses", nu, 1);
        check("p3_d_out", int'(d_out), 2);

        repeat (2) step(1, 1, 1);
        for (int i = 0; i < 15; i++) press(0, 1);
        check("p4_d_15", int'(d_out), 15);
        press(0, 1);
        check("p4_wrap_0", int'(d_out), 0);
        press(1, 0);
        check("p4_down_wrap", int'(d_out), 15);

        co = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            co += int'(up_pulse && dn_pulse);
        end
        check("p5_coincide", co, 1);
        check("p5_d_out", int'(d_out), 15);
        repeat (14) step(1, 1, 0);

        nu = 0;
        repeat (S) step(0, 1, 0);
        repeat (2) step(0, 1, 1);
        check("p6_no_pulse_rst", nu, 0);
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 0);
            if (up_pulse && first == 0) first = i;
        end
        check("p6_pulse_edge", first, S + 3);
        check("p6_pulses", nu, 1);
        repeat (14) step(1, 1, 0);

        tu = 1; td = 1; hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                tu = 1'($urandom_range(0, 1));
                td = 1'($urandom_range(0, 1));
                hold = $urandom_range(4, 30);
            end
            hold--;
            bu = tu ^ ($urandom_range(0, 9) == 0);
            bd = td ^ ($urandom_range(0, 9) == 0);
            step(bu, bd, $urandom_range(0, 249) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
